// File: rtl/datapath_gen_pkg.sv
// datapath_gen_pkg: shared encodings for the parametrised CPU datapath.
// Optional build macro used by the datapath: DATAPATH_GEN_FWD_EN.
package datapath_gen_pkg;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_NOTB  = 3'b011,
        ALU_OR    = 3'b100,
        ALU_XOR   = 3'b101,
        ALU_MUL   = 3'b110,
        ALU_PASSB = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_PASS = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        VSEL_MDATA = 2'b00,
        VSEL_IMM8  = 2'b01,
        VSEL_PC    = 2'b10,
        VSEL_C     = 2'b11
    } vsel_e;

    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_V = 2;

endpackage

// File: rtl/datapath_gen_mul.sv
// datapath_gen_mul: iterative shift-add multiplier, one multiplier bit per cycle.
// Handshake: start is sampled only while busy=0; busy rises at that edge and
// stays high for WIDTH edges; last is high during the final busy cycle (the
// product output is valid then) and done is a one-cycle pulse right after it.
module datapath_gen_mul #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             last,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign last     = busy && (cnt == CW'(WIDTH - 1));
    assign product  = acc_next;

    // Capture operands on start, then add/shift one bit per edge until the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (start && !busy) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            done   <= last;
            if (last) busy <= 1'b0;
        end else begin
            done   <= 1'b0;
        end
    end

endmodule

// File: rtl/datapath_gen.sv
// datapath_gen: register file, A/B latches, shifter, ALU, C and {V,N,Z} status.
// Build macro DATAPATH_GEN_FWD_EN: when defined, register-file reads bypass the
// same-cycle write data; when undefined, reads return the stored value.
module datapath_gen
    import datapath_gen_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int PC_W  = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] readnum1,
    input  logic [$clog2(NREGS)-1:0] readnum2,
    input  logic [$clog2(NREGS)-1:0] writenum,
    input  logic                     write,
    input  logic [1:0]               vsel,
    input  logic [WIDTH-1:0]         mdata,
    input  logic [WIDTH-1:0]         sximm8,
    input  logic [WIDTH-1:0]         sximm5,
    input  logic [PC_W-1:0]          pc,
    input  logic                     loadab,
    input  logic                     asel,
    input  logic                     bsel,
    input  logic [1:0]               shift,
    input  logic [2:0]               aluop,
    input  logic                     loadc,
    input  logic                     loads,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         datapath_out,
    output logic [2:0]               status_out,
    output logic [WIDTH-1:0]         data_out1
);
    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] data_in, rd1, rd2;
    logic [WIDTH-1:0] a_q, b_q, sh_out, ain, bin, alu_out;
    logic             alu_v, mul_last, is_mul;
    logic [WIDTH-1:0] mul_product;

    assign is_mul = (alu_op_e'(aluop) == ALU_MUL);

    // Write-back source selection.
    always_comb begin
        data_in = '0;
        case (vsel_e'(vsel))
            VSEL_MDATA: data_in = mdata;
            VSEL_IMM8:  data_in = sximm8;
            VSEL_PC:    data_in = WIDTH'(pc);
            VSEL_C:     data_in = datapath_out;
            default:    data_in = '0;
        endcase
    end

`ifdef DATAPATH_GEN_FWD_EN
    assign rd1 = (write && (readnum1 == writenum)) ? data_in : regs[readnum1];
    assign rd2 = (write && (readnum2 == writenum)) ? data_in : regs[readnum2];
`else
    assign rd1 = regs[readnum1];
    assign rd2 = regs[readnum2];
`endif
    assign data_out1 = rd1;

    // Register file and A/B operand latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (write) regs[writenum] <= data_in;
            if (loadab) begin
                a_q <= rd2;
                b_q <= rd1;
            end
        end
    end

    // Shifter on B, then operand muxes.
    always_comb begin
        sh_out = b_q;
        case (shift_e'(shift))
            SH_PASS: sh_out = b_q;
            SH_LSL:  sh_out = {b_q[WIDTH-2:0], 1'b0};
            SH_LSR:  sh_out = {1'b0, b_q[WIDTH-1:1]};
            SH_ASR:  sh_out = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
            default: sh_out = b_q;
        endcase
    end

    assign ain = asel ? '0 : a_q;
    assign bin = bsel ? sximm5 : sh_out;

    // ALU; overflow is only meaningful for add and subtract.
    always_comb begin
        alu_out = '0;
        alu_v   = 1'b0;
        case (alu_op_e'(aluop))
            ALU_ADD: begin
                alu_out = ain + bin;
                alu_v   = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_out[WIDTH-1] != ain[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_out = ain - bin;
                alu_v   = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_out[WIDTH-1] != ain[WIDTH-1]);
            end
            ALU_AND:   alu_out = ain & bin;
            ALU_NOTB:  alu_out = ~bin;
            ALU_OR:    alu_out = ain | bin;
            ALU_XOR:   alu_out = ain ^ bin;
            ALU_MUL:   alu_out = '0;
            ALU_PASSB: alu_out = bin;
            default:   alu_out = '0;
        endcase
    end

    datapath_gen_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (start && is_mul),
        .a       (ain),
        .b       (bin),
        .busy    (busy),
        .done    (done),
        .last    (mul_last),
        .product (mul_product)
    );

    // C and status: the multiplier result wins; direct loads are blocked while busy or on MUL.
    always_ff @(posedge clk) begin
        if (reset) begin
            datapath_out <= '0;
            status_out   <= '0;
        end else if (mul_last) begin
            datapath_out         <= mul_product;
            status_out[STAT_V]   <= 1'b0;
            status_out[STAT_N]   <= mul_product[WIDTH-1];
            status_out[STAT_Z]   <= (mul_product == '0);
        end else if (!busy && !is_mul) begin
            if (loadc) datapath_out <= alu_out;
            if (loads) begin
                status_out[STAT_V] <= alu_v;
                status_out[STAT_N] <= alu_out[WIDTH-1];
                status_out[STAT_Z] <= (alu_out == '0);
            end
        end
    end

endmodule

// File: tb/tb_datapath_gen.sv
// tb_datapath_gen: directed bench for datapath_gen with WIDTH=16, NREGS=8, PC_W=9.
module tb_datapath_gen;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    readnum1, readnum2, writenum;
    logic          write;
    logic [1:0]    vsel;
    logic [W-1:0]  mdata, sximm8, sximm5;
    logic [8:0]    pc;
    logic          loadab, asel, bsel;
    logic [1:0]    shift;
    logic [2:0]    aluop;
    logic          loadc, loads, start;
    logic          busy, done;
    logic [W-1:0]  datapath_out, data_out1;
    logic [2:0]    status_out;

    int nvec = 0;
    int nerr = 0;

    datapath_gen #(.WIDTH(W), .NREGS(8), .PC_W(9)) dut (
        .clk(clk), .reset(reset), .readnum1(readnum1), .readnum2(readnum2),
        .writenum(writenum), .write(write), .vsel(vsel), .mdata(mdata),
        .sximm8(sximm8), .sximm5(sximm5), .pc(pc), .loadab(loadab), .asel(asel),
        .bsel(bsel), .shift(shift), .aluop(aluop), .loadc(loadc), .loads(loads),
        .start(start), .busy(busy), .done(done), .datapath_out(datapath_out),
        .status_out(status_out), .data_out1(data_out1)
    );

    // Clock
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] idx, input logic [W-1:0] val);
        vsel = 2'b01; sximm8 = val; writenum = idx; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic load_ab(input logic [2:0] a_idx, input logic [2:0] b_idx);
        readnum2 = a_idx; readnum1 = b_idx; loadab = 1'b1;
        tick();
        loadab = 1'b0;
    endtask

    task automatic do_alu(input logic [2:0] op, input logic [1:0] sh, input logic as);
        aluop = op; shift = sh; asel = as; bsel = 1'b0; loadc = 1'b1; loads = 1'b1;
        tick();
        loadc = 1'b0; loads = 1'b0; shift = 2'b00; asel = 1'b0;
    endtask

    task automatic test_reset();
        write_reg(3'd3, 16'h1234);
        readnum1 = 3'd3; #1;
        nvec++;
        if (data_out1 !== 16'h1234) begin nerr++; $display("FAIL rst_pre_r3: got %h want 1234", data_out1); end
        reset = 1'b1; tick(); reset = 1'b0; #1;
        nvec++;
        if (data_out1 !== 16'h0000) begin nerr++; $display("FAIL rst_r3: got %h want 0000", data_out1); end
        nvec++;
        if (datapath_out !== 16'h0000) begin nerr++; $display("FAIL rst_c: got %h want 0000", datapath_out); end
        nvec++;
        if (status_out !== 3'b000) begin nerr++; $display("FAIL rst_status: got %b want 000", status_out); end
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
    endtask

    task automatic test_add_overflow();
        write_reg(3'd0, 16'h7FFF);
        write_reg(3'd1, 16'h0001);
        load_ab(3'd0, 3'd1);
        do_alu(3'b000, 2'b00, 1'b0);
        nvec++;
        if (datapath_out !== 16'h8000) begin nerr++; $display("FAIL add_ovf_c: got %h want 8000", datapath_out); end
        nvec++;
        if (status_out !== 3'b110) begin nerr++; $display("FAIL add_ovf_status: got %b want 110", status_out); end
        // 0x8000 - 1 overflows to positive
        write_reg(3'd0, 16'h8000);
        load_ab(3'd0, 3'd1);
        do_alu(3'b001, 2'b00, 1'b0);
        nvec++;
        if (datapath_out !== 16'h7FFF || status_out !== 3'b100) begin
            nerr++; $display("FAIL sub_ovf: got %h/%b want 7fff/100", datapath_out, status_out);
        end
    endtask

    task automatic test_sub_shift();
        write_reg(3'd4, 16'h0055);
        load_ab(3'd4, 3'd4);
        do_alu(3'b001, 2'b00, 1'b0);
        nvec++;
        if (datapath_out !== 16'h0000 || status_out !== 3'b001) begin
            nerr++; $display("FAIL sub_zero: got %h/%b want 0000/001", datapath_out, status_out);
        end
        write_reg(3'd5, 16'h8004);
        load_ab(3'd4, 3'd5);
        do_alu(3'b000, 2'b11, 1'b1);
        nvec++;
        if (datapath_out !== 16'hC002 || status_out !== 3'b010) begin
            nerr++; $display("FAIL asr_add: got %h/%b want c002/010", datapath_out, status_out);
        end
    endtask

    task automatic test_logic_ops();
        logic [2:0]   ops [6] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b111, 3'b111};
        logic [1:0]   shs [6] = '{2'b00,  2'b00,  2'b00,  2'b00,  2'b01,  2'b10};
        logic [W-1:0] exp_c [6] = '{16'h000F, 16'hFF00, 16'h0FFF, 16'h0FF0, 16'h01FE, 16'h007F};
        logic [2:0]   exp_s [6] = '{3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
        write_reg(3'd6, 16'h0F0F);
        write_reg(3'd7, 16'h00FF);
        load_ab(3'd6, 3'd7);
        for (int i = 0; i < 6; i++) begin
            do_alu(ops[i], shs[i], 1'b0);
            nvec++;
            if (datapath_out !== exp_c[i] || status_out !== exp_s[i]) begin
                nerr++; $display("FAIL logic_op%0d: got %h/%b want %h/%b", i, datapath_out, status_out, exp_c[i], exp_s[i]);
            end
        end
        // loadc/loads with the multiply opcode must not touch C or status
        do_alu(3'b110, 2'b00, 1'b0);
        nvec++;
        if (datapath_out !== 16'h007F || status_out !== 3'b000) begin
            nerr++; $display("FAIL mul_loadc_ignored: got %h/%b want 007f/000", datapath_out, status_out);
        end
    endtask

    task automatic test_writeback();
        vsel = 2'b00; mdata = 16'hA5A5; writenum = 3'd5; write = 1'b1; tick();
        vsel = 2'b10; pc = 9'h1FF; writenum = 3'd6; tick();
        vsel = 2'b11; writenum = 3'd7; tick();
        write = 1'b0;
        readnum1 = 3'd5; #1;
        nvec++;
        if (data_out1 !== 16'hA5A5) begin nerr++; $display("FAIL wb_mdata: got %h want a5a5", data_out1); end
        readnum1 = 3'd6; #1;
        nvec++;
        if (data_out1 !== 16'h01FF) begin nerr++; $display("FAIL wb_pc: got %h want 01ff", data_out1); end
        readnum1 = 3'd7; #1;
        nvec++;
        if (data_out1 !== 16'h007F) begin nerr++; $display("FAIL wb_c: got %h want 007f", data_out1); end
    endtask

    task automatic test_multiply();
        int lat;
        write_reg(3'd2, 16'h0003);
        write_reg(3'd3, 16'h0005);
        load_ab(3'd2, 3'd3);
        aluop = 3'b110; start = 1'b1; tick(); start = 1'b0;
        nvec++;
        if (busy !== 1'b1) begin nerr++; $display("FAIL mul_busy_e0: got %b want 1", busy); end
        for (int i = 1; i <= W; i++) begin
            start = (i == 4);
            tick();
            if (i < W) begin
                nvec++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    nerr++; $display("FAIL mul_busy_c%0d: got %b%b want 10", i, busy, done);
                end
            end
        end
        start = 1'b0;
        nvec++;
        if (busy !== 1'b0 || done !== 1'b1) begin nerr++; $display("FAIL mul_done: got %b%b want 01", busy, done); end
        nvec++;
        if (datapath_out !== 16'h000F || status_out !== 3'b000) begin
            nerr++; $display("FAIL mul_3x5: got %h/%b want 000f/000", datapath_out, status_out);
        end
        tick();
        nvec++;
        if (done !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL mul_pulse: got %b%b want 00", busy, done); end
        // 0x0100 * 0x0100 wraps to zero
        write_reg(3'd2, 16'h0100);
        load_ab(3'd2, 3'd2);
        start = 1'b1; tick(); start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
        nvec++;
        if (lat !== W) begin nerr++; $display("FAIL mul_latency: got %0d want %0d", lat, W); end
        nvec++;
        if (datapath_out !== 16'h0000 || status_out !== 3'b001) begin
            nerr++; $display("FAIL mul_wrap: got %h/%b want 0000/001", datapath_out, status_out);
        end
        tick();
    endtask

    task automatic test_mul_reset_abort();
        int lat;
        int seen;
        write_reg(3'd6, 16'h0007);
        write_reg(3'd7, 16'h0009);
        load_ab(3'd6, 3'd7);
        aluop = 3'b110; start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0 || datapath_out !== 16'h0000) begin
            nerr++; $display("FAIL abort_state: got %b%b/%h want 00/0000", busy, done, datapath_out);
        end
        seen = 0;
        for (int i = 0; i < W + 2; i++) begin tick(); if (done === 1'b1) seen++; end
        nvec++;
        if (seen !== 0) begin nerr++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
        write_reg(3'd6, 16'h0007);
        write_reg(3'd7, 16'h0009);
        load_ab(3'd6, 3'd7);
        start = 1'b1; tick(); start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
        nvec++;
        if (lat !== W || datapath_out !== 16'h003F) begin
            nerr++; $display("FAIL mul_after_abort: got lat %0d c %h want %0d/003f", lat, datapath_out, W);
        end
        tick();
    endtask

    task automatic test_forwarding();
        logic [W-1:0] exp_same, exp_sum;
        logic [2:0]   exp_st;
`ifdef DATAPATH_GEN_FWD_EN
        exp_same = 16'hBEEF; exp_sum = 16'h2222; exp_st = 3'b000;
`else
        exp_same = 16'h0000; exp_sum = 16'h7DDE; exp_st = 3'b100;
`endif
        // R2 is zero after the previous reset
        readnum1 = 3'd2; vsel = 2'b01; sximm8 = 16'hBEEF; writenum = 3'd2; write = 1'b1; #1;
        nvec++;
        if (data_out1 !== exp_same) begin nerr++; $display("FAIL fwd_read: got %h want %h", data_out1, exp_same); end
        tick(); write = 1'b0; #1;
        nvec++;
        if (data_out1 !== 16'hBEEF) begin nerr++; $display("FAIL fwd_after: got %h want beef", data_out1); end
        // same-cycle write and loadab of R2 into both A and B
        readnum1 = 3'd2; readnum2 = 3'd2; sximm8 = 16'h1111; write = 1'b1; loadab = 1'b1;
        tick();
        write = 1'b0; loadab = 1'b0;
        do_alu(3'b000, 2'b00, 1'b0);
        nvec++;
        if (datapath_out !== exp_sum || status_out !== exp_st) begin
            nerr++; $display("FAIL fwd_loadab: got %h/%b want %h/%b", datapath_out, status_out, exp_sum, exp_st);
        end
    endtask

    initial begin
        reset = 1'b1; readnum1 = '0; readnum2 = '0; writenum = '0; write = 1'b0;
        vsel = '0; mdata = '0; sximm8 = '0; sximm5 = '0; pc = '0; loadab = 1'b0;
        asel = 1'b0; bsel = 1'b0; shift = '0; aluop = '0; loadc = 1'b0; loads = 1'b0;
        start = 1'b0;
        tick(); tick();
        reset = 1'b0;
        test_reset();
        test_add_overflow();
        test_sub_shift();
        test_logic_ops();
        test_writeback();
        test_multiply();
        test_mul_reset_abort();
        test_forwarding();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

endmodule
